// File: rtl/reg_file_wr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_file_wr_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: A (ALU writeback) and B (load / long-latency unit).
//
// Each requester feeds a 1-entry holding buffer through a valid/ready
// handshake. At most one buffer drains per cycle into the write port.
// Buffers that were filled on different edges drain oldest first. A pair
// filled on the same edge is ordered by a round-robin pointer, and that
// pointer flips after each such pair.
//
// Optional build macro:
//   RF_WR_ARB_STATS_EN - adds the 16-bit saturating stall counters
//                        stall_a_cnt / stall_b_cnt. When it is undefined,
//                        the ports and counters are absent.
//
// Ports:
//   clk                 clock; the register file writes on posedge clk
//   rst_n               synchronous active-low reset
//   a_valid / b_valid   requester has a write to deliver
//   a_ready / b_ready   handshake is accepted this cycle
//   a_reg   / b_reg     destination register index
//   a_data  / b_data    write data
//   wr_en               register-file write enable
//   wr_reg              register-file write index (zero when idle)
//   wr_data             register-file write data (zero when idle)
//   pending             at least one holding buffer is full
//   stall_a_cnt         (macro only) cycles with a_valid & !a_ready
//   stall_b_cnt         (macro only) cycles with b_valid & !b_ready
// -----------------------------------------------------------------------------
module reg_file_wr_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [XLEN-1:0]       a_data,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [XLEN-1:0]       b_data,

    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [XLEN-1:0]       wr_data,
    output logic                  pending
`ifdef RF_WR_ARB_STATS_EN
    ,
    output logic [15:0]           stall_a_cnt,
    output logic [15:0]           stall_b_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Holding buffers and shared ordering state
    // -------------------------------------------------------------------------
    logic                  full_a;
    logic                  full_b;
    logic [REG_ADDR_W-1:0] reg_a;
    logic [REG_ADDR_W-1:0] reg_b;
    logic [XLEN-1:0]       data_a;
    logic [XLEN-1:0]       data_b;

    // older: 0 = A holds the older write, 1 = B does.
    // older is only used when both buffers are full and tie is 0.
    logic                  older;
    // tie: both buffers are full and were filled on the same edge.
    logic                  tie;
    // rr: order for a same-edge pair (0 = A first, 1 = B first).
    logic                  rr;

    logic                  gnt_a;
    logic                  gnt_b;
    logic                  tie_resolved;
    logic                  acc_a;
    logic                  acc_b;
    logic                  keep_a;
    logic                  keep_b;
    logic [REG_ADDR_W-1:0] gnt_reg;
    logic [XLEN-1:0]       gnt_data;

    // -------------------------------------------------------------------------
    // Grant selection. It depends on buffer state only, so the write port
    // never has a combinational path from the requester inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_a        = 1'b0;
        gnt_b        = 1'b0;
        tie_resolved = 1'b0;
        if (full_a && full_b) begin
            if (tie) begin
                tie_resolved = 1'b1;
                if (!rr) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else if (!older) begin
                gnt_a = 1'b1;
            end else begin
                gnt_b = 1'b1;
            end
        end else if (full_a) begin
            gnt_a = 1'b1;
        end else if (full_b) begin
            gnt_b = 1'b1;
        end
    end

    // A buffer that is draining this cycle can take a new write on the same
    // edge. This lets one requester sustain one write per cycle.
    assign a_ready = !full_a || gnt_a;
    assign b_ready = !full_b || gnt_b;

    assign acc_a   = a_valid && a_ready;
    assign acc_b   = b_valid && b_ready;
    assign keep_a  = full_a && !gnt_a;
    assign keep_b  = full_b && !gnt_b;

    assign pending = full_a || full_b;

    // -------------------------------------------------------------------------
    // Write port. The granted entry is muxed onto the port, and the port reads
    // zero when nothing is granted. An x0 entry still uses up its grant, but it
    // does not raise wr_en. wr_en is also masked while rst_n is low, so a write
    // that is buffered when reset arrives never lands in the register file.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_reg  = '0;
        gnt_data = '0;
        if (gnt_a) begin
            gnt_reg  = reg_a;
            gnt_data = data_a;
        end else if (gnt_b) begin
            gnt_reg  = reg_b;
            gnt_data = data_b;
        end
    end

    assign wr_reg  = gnt_reg;
    assign wr_data = gnt_data;
    assign wr_en   = rst_n && (gnt_a || gnt_b) && (gnt_reg != '0);

    // -------------------------------------------------------------------------
    // Control state: buffer occupancy, age, tie flag and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_a <= 1'b0;
            full_b <= 1'b0;
            older  <= 1'b0;
            tie    <= 1'b0;
            rr     <= 1'b0;
        end else begin
            full_a <= acc_a || keep_a;
            full_b <= acc_b || keep_b;

            // The pointer only advances after it has actually ordered a pair.
            if (tie_resolved) begin
                rr <= !rr;
            end

            // A kept buffer can never be refilled, because it is not granted
            // and therefore not ready. When both buffers end up full, at most
            // one of them can be the kept, older one.
            if (keep_a && acc_b) begin
                older <= 1'b0;
                tie   <= 1'b0;
            end else if (keep_b && acc_a) begin
                older <= 1'b1;
                tie   <= 1'b0;
            end else if (acc_a && acc_b) begin
                older <= 1'b0;
                tie   <= 1'b1;
            end else begin
                older <= 1'b0;
                tie   <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Buffer payloads. They are not reset, because every read is qualified by
    // the full flags.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (acc_a) begin
            reg_a  <= a_reg;
            data_a <= a_data;
        end
        if (acc_b) begin
            reg_b  <= b_reg;
            data_b <= b_data;
        end
    end

`ifdef RF_WR_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Stall statistics. Each counter saturates so that a long stall does not
    // wrap back to a small value.
    // -------------------------------------------------------------------------
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end
        return val + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_a_cnt <= '0;
            stall_b_cnt <= '0;
        end else begin
            if (a_valid && !a_ready) begin
                stall_a_cnt <= sat_inc16(stall_a_cnt);
            end
            if (b_valid && !b_ready) begin
                stall_b_cnt <= sat_inc16(stall_b_cnt);
            end
        end
    end
`endif

endmodule
